mmio_out_sequencer: RTL and testbench
=====================================

Name: mmio_out_sequencer

Overview:
- Sequences memory-mapped stores onto the single output-port peripheral bus (active-low chip enable, write enable, 32-bit data; the peripheral captures on the falling clock edge).
- Arbitrates round-robin between two requesters: port 0 is the CPU store path and port 1 is the debug/boot-loader path.
- Decodes the address and either strobes the peripheral or returns an error.
- Sits between the multi-cycle core's memory stage and the output pin register.

Parameters:
- BASE_ADDR, 32'h0000_0400, address of the output port.
- ADDR_MASK, 32'hFFFF_FFFC, a hit is (addr & ADDR_MASK) == BASE_ADDR.
- STROBE_CYCLES, 1, number of cycles nce_out is held low per write; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 write request, level, held until ack0 or err0.
- addr0  in  32  requester 0 byte address.
- wdata0  in  32  requester 0 write data.
- ack0  out  1  one-cycle pulse: requester 0 write performed.
- err0  out  1  one-cycle pulse: requester 0 address miss, no write performed.
- req1, addr1, wdata1, ack1, err1: same as the requester 0 ports, for requester 1.
- nce_out  out  1  peripheral chip enable, active-low.
- we_out  out  1  peripheral write enable.
- d_out  out  32  peripheral write data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE, nce_out=1, we_out=0, d_out=0.
  - ack0/1=0, err0/1=0, last_grant=1, so req0 wins the first contention.
  - strobe counter=0.
- All outputs are registered.
- States:
  - IDLE: if any req is high, pick the winner, latch the winner's addr/wdata and the hit flag, then go to SETUP. Otherwise stay in IDLE.
  - SETUP: d_out=latched data, nce_out=1, we_out=0. Hit goes to STROBE with counter=STROBE_CYCLES-1. Miss goes to DONE with error flagged.
  - STROBE: nce_out=0, we_out=1, d_out held. When counter==0 go to DONE; otherwise decrement the counter.
  - DONE: nce_out=1, we_out=0. Pulse ack (hit) or err (miss) on the granted port for exactly one cycle. Update last_grant. Go to IDLE.
- Arbitration:
  - One requester high: it wins.
  - Both high: the requester != last_grant wins.
  - last_grant updates only in DONE.
- Latency with STROBE_CYCLES=1 and req sampled in IDLE at cycle 0:
  - SETUP at cycle 1, STROBE at cycle 2, ack at cycle 3, IDLE at cycle 4.
  - A requester that holds req continuously gets a new transaction every 4 cycles.
  - The general hit length is 3+STROBE_CYCLES cycles. A miss takes 3 cycles and asserts no strobe.
- d_out is stable from SETUP through DONE. This guarantees setup and hold around every falling edge during STROBE.
- Requester handshake:
  - The requester must deassert req in the cycle after ack or err.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
  - Request data is latched in IDLE. Changes to addr/wdata or a dropped req after that are ignored, and the transaction completes with its ack/err still pulsed.
- ack and err are never both high. At most one port's ack or err is high in any cycle.
- Reset during STROBE: nce_out rises asynchronously and the write is abandoned without an ack. The peripheral may or may not have captured the data.
- Counter width is 4 bits. STROBE_CYCLES outside 1..15 is a configuration error, flagged by a simulation-only check.

Decomposition:
- Shared package mmio_pkg holds:
  - the state enumeration (IDLE, SETUP, STROBE, DONE; 2-bit encoding);
  - the OUT_PORT_BASE and OUT_PORT_MASK constants used as parameter defaults;
  - the grant index constants.
- Sub-module rr_arb2 is combinational:
  - inputs req0, req1, last_grant;
  - outputs grant_valid, grant_idx.
- Everything else lives in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> nce_out=1, we_out=0, d_out=0, all ack/err=0, busy=0 without waiting for a clock edge.
- Single hit: req0 with addr0=0x0000_0400, wdata0=0x0000_03FF -> nce_out=0 and we_out=1 only in cycle 2, d_out=0x3FF in cycles 1-3, ack0 pulse in cycle 3, err0 never asserted.
- Contention: req0 and req1 held together, data 0xA and 0xB -> d_out sequence 0xA, 0xB, 0xA, 0xB with acks alternating 0,1,0,1, each 4 cycles apart.
- Miss: req1 with addr1=0x0000_0800 -> err1 pulse in cycle 2, nce_out stays 1 throughout, ack1 never asserted.
- Stretch: STROBE_CYCLES=3 with a hit -> nce_out low for exactly 3 consecutive cycles, ack in cycle 5.
- Reset mid-op: rst_n=0 during STROBE -> nce_out=1 immediately, no ack. After release, a pending req0 starts a fresh transaction from IDLE.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the output-port store sequencer.
//   state_t        : sequencer FSM states (2-bit encoding)
//   OUT_PORT_BASE  : default byte address of the output port
//   OUT_PORT_MASK  : default address compare mask
//   GRANT_0/1      : requester index values used by the arbiter and grant logic
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] OUT_PORT_BASE = 32'h0000_0400;
  localparam logic [31:0] OUT_PORT_MASK = 32'hFFFF_FFFC;

  localparam logic GRANT_0 = 1'b0;
  localparam logic GRANT_1 = 1'b1;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mmio_out_sequencer_rr_arb2.sv
// Two-way round-robin arbiter (combinational).
//   req0, req1  : request levels
//   last_grant  : index granted by the previous completed transaction
//   grant_valid : at least one request present
//   grant_idx   : winning requester index
module rr_arb2
  import mmio_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = GRANT_0;
    if (req0 && req1) begin
      // Under contention the requester that did not win last time goes next.
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = GRANT_1;
    end
  end

endmodule

// File: rtl/mmio_out_sequencer.sv
// Store sequencer for the single output-port peripheral bus.
// Arbitrates between the CPU store path (port 0) and the debug/boot-loader
// path (port 1), decodes the address and either strobes the peripheral or
// returns an error pulse.
//   clk, rst_n           : clock, async active-low reset
//   req/addr/wdata 0,1   : requester write requests (level, held until ack/err)
//   ack0/1, err0/1       : one-cycle completion / address-miss pulses
//   nce_out, we_out      : peripheral chip enable (active-low), write enable
//   d_out                : peripheral write data
//   busy                 : high whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for a request; winner's data and hit flag latched on exit
// SETUP  | data driven onto d_out, strobe inactive
// STROBE | nce_out low / we_out high for STROBE_CYCLES cycles
// DONE   | strobe released, ack or err pulsed on the granted port
module mmio_out_sequencer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = OUT_PORT_BASE,
  parameter logic [31:0] ADDR_MASK     = OUT_PORT_MASK,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic        nce_out,
  output logic        we_out,
  output logic [31:0] d_out,
  output logic        busy
);

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_cfg_err
    $error("mmio_out_sequencer: STROBE_CYCLES=%0d outside 1..15", STROBE_CYCLES);
  end

  state_t      r_state;
  state_t      w_next;
  logic        w_gvalid;
  logic        w_gidx;
  logic        w_sel_hit;
  logic [31:0] w_sel_data;
  logic        r_gidx;
  logic        r_hit;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic        r_nce;
  logic        r_we;
  logic [31:0] r_dout;
  logic        r_busy;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;

  rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (r_last),
    .grant_valid (w_gvalid),
    .grant_idx   (w_gidx)
  );

  always_comb begin
    w_sel_data = wdata0;
    w_sel_hit  = addr_hit(addr0, BASE_ADDR, ADDR_MASK);
    if (w_gidx == GRANT_1) begin
      w_sel_data = wdata1;
      w_sel_hit  = addr_hit(addr1, BASE_ADDR, ADDR_MASK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_gvalid) w_next = SETUP;
      SETUP:   w_next = r_hit ? STROBE : DONE;
      STROBE:  if (r_cnt == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered outputs. Outputs are computed from the next
  // state so that they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gidx <= GRANT_0;
      r_hit  <= 1'b0;
      r_last <= GRANT_1;
      r_cnt  <= 4'd0;
      r_nce  <= 1'b1;
      r_we   <= 1'b0;
      r_dout <= 32'd0;
      r_busy <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      if (r_state == IDLE && w_gvalid) begin
        r_gidx <= w_gidx;
        r_hit  <= w_sel_hit;
        r_dout <= w_sel_data;
      end
      if (r_state == SETUP && r_hit) begin
        r_cnt <= STROBE_LOAD;
      end else if (r_state == STROBE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == DONE) begin
        r_last <= r_gidx;
      end
      r_nce  <= (w_next != STROBE);
      r_we   <= (w_next == STROBE);
      r_busy <= (w_next != IDLE);
      r_ack0 <= (w_next == DONE) &&  r_hit && (r_gidx == GRANT_0);
      r_ack1 <= (w_next == DONE) &&  r_hit && (r_gidx == GRANT_1);
      r_err0 <= (w_next == DONE) && !r_hit && (r_gidx == GRANT_0);
      r_err1 <= (w_next == DONE) && !r_hit && (r_gidx == GRANT_1);
    end
  end

  assign nce_out = r_nce;
  assign we_out  = r_we;
  assign d_out   = r_dout;
  assign busy    = r_busy;
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign err0    = r_err0;
  assign err1    = r_err1;

endmodule

// File: tb/tb_mmio_out_sequencer.sv
module tb_mmio_out_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1, nce_out, we_out, busy;
  logic [31:0] d_out;

  // Second instance with a stretched strobe, own requester 0 inputs.
  logic        s_req0;
  logic [31:0] s_addr0, s_wdata0;
  logic        s_ack0, s_ack1, s_err0, s_err1, s_nce, s_we, s_busy;
  logic [31:0] s_dout;
  logic        s_req1 = 1'b0;
  logic [31:0] s_addr1 = 32'd0;
  logic [31:0] s_wdata1 = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_out_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .err1(err1),
    .nce_out(nce_out), .we_out(we_out), .d_out(d_out), .busy(busy)
  );

  mmio_out_sequencer #(.STROBE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(s_req0), .addr0(s_addr0), .wdata0(s_wdata0), .ack0(s_ack0), .err0(s_err0),
    .req1(s_req1), .addr1(s_addr1), .wdata1(s_wdata1), .ack1(s_ack1), .err1(s_err1),
    .nce_out(s_nce), .we_out(s_we), .d_out(s_dout), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    s_req0 = 0; s_addr0 = 0; s_wdata0 = 0;

    // Asynchronous reset asserted mid-cycle.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst nce", 32'(nce_out), 32'd1);
    chk("rst we", 32'(we_out), 32'd0);
    chk("rst d_out", d_out, 32'd0);
    chk("rst ack0", 32'(ack0), 32'd0);
    chk("rst ack1", 32'(ack1), 32'd0);
    chk("rst err0", 32'(err0), 32'd0);
    chk("rst err1", 32'(err1), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst s_nce", 32'(s_nce), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention: both held, req0 first after reset, then alternating.
    req0 = 1; addr0 = 32'h0000_0400; wdata0 = 32'h0000_000A;
    req1 = 1; addr1 = 32'h0000_0400; wdata1 = 32'h0000_000B;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk($sformatf("cont ack0 c%0d", c), 32'(ack0), 32'(c == 3 || c == 11));
      chk($sformatf("cont ack1 c%0d", c), 32'(ack1), 32'(c == 7 || c == 15));
      chk($sformatf("cont err c%0d", c), 32'(err0 | err1), 32'd0);
      chk($sformatf("cont nce c%0d", c), 32'(nce_out), 32'(c % 4 != 2));
      chk($sformatf("cont busy c%0d", c), 32'(busy), 32'(c % 4 != 0));
      if (c % 4 == 1)
        chk($sformatf("cont d_out c%0d", c), d_out, ((c / 4) % 2 == 0) ? 32'hA : 32'hB);
      if (c == 15) begin req0 = 0; req1 = 0; end
    end
    step();
    chk("cont idle busy", 32'(busy), 32'd0);

    // Single hit on port 0.
    req0 = 1; addr0 = 32'h0000_0400; wdata0 = 32'h0000_03FF;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c <= 3) chk($sformatf("hit d_out c%0d", c), d_out, 32'h0000_03FF);
      chk($sformatf("hit nce c%0d", c), 32'(nce_out), 32'(c != 2));
      chk($sformatf("hit we c%0d", c), 32'(we_out), 32'(c == 2));
      chk($sformatf("hit ack0 c%0d", c), 32'(ack0), 32'(c == 3));
      chk($sformatf("hit err0 c%0d", c), 32'(err0), 32'd0);
      chk($sformatf("hit busy c%0d", c), 32'(busy), 32'(c != 4));
      if (c == 3) req0 = 0;
    end

    // Miss on port 1.
    req1 = 1; addr1 = 32'h0000_0800; wdata1 = 32'h5A5A_5A5A;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("miss err1 c%0d", c), 32'(err1), 32'(c == 2));
      chk($sformatf("miss ack1 c%0d", c), 32'(ack1), 32'd0);
      chk($sformatf("miss nce c%0d", c), 32'(nce_out), 32'd1);
      chk($sformatf("miss we c%0d", c), 32'(we_out), 32'd0);
      chk($sformatf("miss busy c%0d", c), 32'(busy), 32'(c != 3));
      if (c == 1) chk("miss d_out c1", d_out, 32'h5A5A_5A5A);
      if (c == 2) req1 = 0;
    end

    // Stretched strobe; 0x403 is inside the masked window.
    s_req0 = 1; s_addr0 = 32'h0000_0403; s_wdata0 = 32'h00C0_FFEE;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("str nce c%0d", c), 32'(s_nce), 32'(!(c >= 2 && c <= 4)));
      chk($sformatf("str we c%0d", c), 32'(s_we), 32'(c >= 2 && c <= 4));
      chk($sformatf("str ack0 c%0d", c), 32'(s_ack0), 32'(c == 5));
      chk($sformatf("str busy c%0d", c), 32'(s_busy), 32'(c != 6));
      if (c <= 5) chk($sformatf("str d_out c%0d", c), s_dout, 32'h00C0_FFEE);
      if (c == 5) s_req0 = 0;
    end

    // 0x408 lies just outside the window.
    s_req0 = 1; s_addr0 = 32'h0000_0408;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("str miss err0 c%0d", c), 32'(s_err0), 32'(c == 2));
      chk($sformatf("str miss nce c%0d", c), 32'(s_nce), 32'd1);
      if (c == 2) s_req0 = 0;
    end

    // Reset while strobing: abandoned without ack, fresh start afterwards.
    req0 = 1; addr0 = 32'h0000_0400; wdata0 = 32'h1234_5678;
    step();
    step();
    chk("rmid pre nce", 32'(nce_out), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("rmid nce", 32'(nce_out), 32'd1);
    chk("rmid we", 32'(we_out), 32'd0);
    chk("rmid busy", 32'(busy), 32'd0);
    chk("rmid ack0", 32'(ack0), 32'd0);
    chk("rmid d_out", d_out, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c <= 3) chk($sformatf("rmid d_out c%0d", c), d_out, 32'h1234_5678);
      chk($sformatf("rmid nce c%0d", c), 32'(nce_out), 32'(c != 2));
      chk($sformatf("rmid ack0 c%0d", c), 32'(ack0), 32'(c == 3));
      chk($sformatf("rmid busy c%0d", c), 32'(busy), 32'(c != 4));
      if (c == 3) req0 = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
